active_list: RTL and testbench

- In-order reorder buffer for the out-of-order MIPS core. Allocates one entry per renamed instruction at dispatch, in parallel with the instruction queue.
- Receives completion reports from execute and commits the oldest completed instruction each cycle, returning its previous physical register to the free list.
- On a branch mispredict it broadcasts the flushed instruction ID, then walks the tail backward to undo renames. It is the producer of the flush and flush-done signals that the instruction queue consumes.

---
 rtl/active_list.sv | 165 ++++++++++++++++
 tb/tb_active_list.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/active_list.sv
`default_nettype none
// ============================================================================
// Module   : active_list
// Brief    : In-order reorder buffer. Allocates at dispatch, retires the
//            oldest completed entry, and walks back the tail after a mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module active_list #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int ID_W   = 32,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ID_W-1:0]   alloc_instruction_ID,
    input  logic              alloc_uses_rw,
    input  logic [4:0]        alloc_arch_rw,
    input  logic [PREG_W-1:0] alloc_phys_rw,
    input  logic [PREG_W-1:0] alloc_prev_phys_rw,
    output logic [IDX_W-1:0]  alloc_index,
    input  logic              complete_valid,
    input  logic [IDX_W-1:0]  complete_index,
    input  logic              complete_mispredict,
    output logic              commit_valid,
    output logic [ID_W-1:0]   commit_instruction_ID,
    output logic              commit_uses_rw,
    output logic [PREG_W-1:0] commit_free_phys,
    output logic              flush_valid,
    output logic [ID_W-1:0]   flushed_instruction_ID,
    output logic              rollback_valid,
    output logic [4:0]        rollback_arch_rw,
    output logic [PREG_W-1:0] rollback_prev_phys,
    output logic [PREG_W-1:0] rollback_free_phys,
    output logic              flushing,
    output logic              flush_done,
    output logic [IDX_W:0]    count
);

    localparam int              CW          = IDX_W + 1;
    localparam logic [IDX_W-1:0] c_one      = IDX_W'(1);
    localparam logic [CW-1:0]    c_full     = CW'(DEPTH);
    localparam logic [0:0]       ST_NORMAL   = 1'b0;
    localparam logic [0:0]       ST_ROLLBACK = 1'b1;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_uses_rw;
    logic [4:0]        r_arch_rw   [DEPTH];
    logic [PREG_W-1:0] r_phys_rw   [DEPTH];
    logic [PREG_W-1:0] r_prev_phys [DEPTH];
    logic [ID_W-1:0]   r_id        [DEPTH];

    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W-1:0]  r_target;
    logic [CW-1:0]     r_count;
    logic [0:0]        r_state;
    logic              r_flush_valid;
    logic [ID_W-1:0]   r_flushed_id;
    logic              r_flush_done;

    logic [IDX_W-1:0]  w_tail_m1;
    logic [IDX_W-1:0]  w_age_ci;
    logic [IDX_W-1:0]  w_age_tgt;
    logic              w_mp_accept;
    logic              w_walk;
    logic              w_walk_end;
    logic              w_pop;
    logic              w_commit;
    logic              w_alloc;

    assign w_tail_m1 = r_tail - c_one;
    assign w_age_ci  = complete_index - r_head;
    assign w_age_tgt = r_target - r_head;

    // Once the branch itself has retired, nothing older remains to retarget to.
    assign w_mp_accept = complete_valid && complete_mispredict && r_valid[complete_index] &&
                         ((r_state == ST_NORMAL) ||
                          (r_valid[r_target] && (w_age_ci < w_age_tgt)));

    // A retarget cycle holds the walk so the new target is compared next cycle.
    assign w_walk     = (r_state == ST_ROLLBACK) && !w_mp_accept;
    assign w_walk_end = w_walk && (w_tail_m1 == r_target);
    assign w_pop      = w_walk && !w_walk_end;

    assign w_commit = r_valid[r_head] && r_done[r_head] && !(w_pop && (r_head == w_tail_m1));

    assign alloc_ready = (r_state == ST_NORMAL) && (r_count != c_full) && !w_mp_accept;
    assign w_alloc     = alloc_valid && alloc_ready;
    assign alloc_index = r_tail;

    assign commit_valid          = w_commit;
    assign commit_instruction_ID = w_commit ? r_id[r_head] : '0;
    assign commit_uses_rw        = w_commit && r_uses_rw[r_head];
    assign commit_free_phys      = w_commit ? r_prev_phys[r_head] : '0;

    assign rollback_valid     = w_pop && r_uses_rw[w_tail_m1];
    assign rollback_arch_rw   = rollback_valid ? r_arch_rw[w_tail_m1]   : '0;
    assign rollback_prev_phys = rollback_valid ? r_prev_phys[w_tail_m1] : '0;
    assign rollback_free_phys = rollback_valid ? r_phys_rw[w_tail_m1]   : '0;

    assign flush_valid            = r_flush_valid;
    assign flushed_instruction_ID = r_flushed_id;
    assign flush_done             = r_flush_done;
    assign flushing               = (r_state == ST_ROLLBACK);
    assign count                  = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= '0;
            r_done        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_target      <= '0;
            r_count       <= '0;
            r_state       <= ST_NORMAL;
            r_flush_valid <= 1'b0;
            r_flushed_id  <= '0;
            r_flush_done  <= 1'b0;
        end else begin
            if (complete_valid && r_valid[complete_index]) begin
                r_done[complete_index] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_one;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + c_one;
            end else if (w_pop) begin
                r_valid[w_tail_m1] <= 1'b0;
                r_tail             <= w_tail_m1;
            end
            r_count <= r_count + CW'(w_alloc) - CW'(w_commit) - CW'(w_pop);

            r_flush_valid <= w_mp_accept;
            r_flushed_id  <= w_mp_accept ? r_id[complete_index] : '0;
            r_flush_done  <= w_walk_end;
            if (w_mp_accept) begin
                r_state  <= ST_ROLLBACK;
                r_target <= complete_index;
            end else if (w_walk_end) begin
                r_state <= ST_NORMAL;
            end
        end
    end

    // Payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_uses_rw[r_tail]   <= alloc_uses_rw;
            r_arch_rw[r_tail]   <= alloc_arch_rw;
            r_phys_rw[r_tail]   <= alloc_phys_rw;
            r_prev_phys[r_tail] <= alloc_prev_phys_rw;
            r_id[r_tail]        <= alloc_instruction_ID;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_active_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_active_list
// Brief    : Directed self-checking bench for active_list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_active_list;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_instruction_ID;
    logic        alloc_uses_rw;
    logic [4:0]  alloc_arch_rw;
    logic [5:0]  alloc_phys_rw;
    logic [5:0]  alloc_prev_phys_rw;
    logic [4:0]  alloc_index;
    logic        complete_valid;
    logic [4:0]  complete_index;
    logic        complete_mispredict;
    logic        commit_valid;
    logic [31:0] commit_instruction_ID;
    logic        commit_uses_rw;
    logic [5:0]  commit_free_phys;
    logic        flush_valid;
    logic [31:0] flushed_instruction_ID;
    logic        rollback_valid;
    logic [4:0]  rollback_arch_rw;
    logic [5:0]  rollback_prev_phys;
    logic [5:0]  rollback_free_phys;
    logic        flushing;
    logic        flush_done;
    logic [5:0]  count;

    int n_checks;
    int n_fail;

    active_list #(.DEPTH(32), .IDX_W(5), .ID_W(32), .PREG_W(6)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .alloc_valid            (alloc_valid),
        .alloc_ready            (alloc_ready),
        .alloc_instruction_ID   (alloc_instruction_ID),
        .alloc_uses_rw          (alloc_uses_rw),
        .alloc_arch_rw          (alloc_arch_rw),
        .alloc_phys_rw          (alloc_phys_rw),
        .alloc_prev_phys_rw     (alloc_prev_phys_rw),
        .alloc_index            (alloc_index),
        .complete_valid         (complete_valid),
        .complete_index         (complete_index),
        .complete_mispredict    (complete_mispredict),
        .commit_valid           (commit_valid),
        .commit_instruction_ID  (commit_instruction_ID),
        .commit_uses_rw         (commit_uses_rw),
        .commit_free_phys       (commit_free_phys),
        .flush_valid            (flush_valid),
        .flushed_instruction_ID (flushed_instruction_ID),
        .rollback_valid         (rollback_valid),
        .rollback_arch_rw       (rollback_arch_rw),
        .rollback_prev_phys     (rollback_prev_phys),
        .rollback_free_phys     (rollback_free_phys),
        .flushing               (flushing),
        .flush_done             (flush_done),
        .count                  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cmp();
        complete_valid      = 1'b0;
        complete_index      = '0;
        complete_mispredict = 1'b0;
    endtask

    task automatic set_cmp(input logic [4:0] idx, input logic mp);
        complete_valid      = 1'b1;
        complete_index      = idx;
        complete_mispredict = mp;
    endtask

    task automatic do_alloc(input logic [31:0] id, input logic [4:0] arch,
                            input logic [5:0] phys, input logic [5:0] prev);
        alloc_valid          = 1'b1;
        alloc_instruction_ID = id;
        alloc_uses_rw        = 1'b1;
        alloc_arch_rw        = arch;
        alloc_phys_rw        = phys;
        alloc_prev_phys_rw   = prev;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic reset_dut();
        alloc_valid = 1'b0;
        clr_cmp();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        alloc_instruction_ID = '0;
        alloc_uses_rw = 1'b0;
        alloc_arch_rw = '0;
        alloc_phys_rw = '0;
        alloc_prev_phys_rw = '0;
        clr_cmp();
        #12;
        check("rst_count", count, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_index", alloc_index, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_flush_valid", flush_valid, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_flushing", flushing, 0);
        check("rst_rollback_valid", rollback_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // In-order commit with out-of-order completion
        for (int i = 0; i < 3; i++) begin
            check("t1_alloc_index", alloc_index, i);
            do_alloc(32'(10 + i), 5'(i + 1), 6'(33 + i), 6'(40 + i));
        end
        check("t1_count3", count, 3);
        set_cmp(5'd2, 1'b0); tick();
        check("t1_no_commit", commit_valid, 0);
        set_cmp(5'd0, 1'b0); tick();
        check("t1_commit0_valid", commit_valid, 1);
        check("t1_commit0_id", commit_instruction_ID, 10);
        check("t1_commit0_free", commit_free_phys, 40);
        check("t1_commit0_uses", commit_uses_rw, 1);
        set_cmp(5'd1, 1'b0); tick(); clr_cmp();
        check("t1_commit1_id", commit_instruction_ID, 11);
        check("t1_commit1_free", commit_free_phys, 41);
        check("t1_count2", count, 2);
        tick();
        check("t1_commit2_id", commit_instruction_ID, 12);
        check("t1_commit2_free", commit_free_phys, 42);
        tick();
        check("t1_commit_idle", commit_valid, 0);
        check("t1_count0", count, 0);

        // Full buffer and pointer wrap
        reset_dut();
        for (int i = 0; i < 32; i++) do_alloc(32'(200 + i), 5'(i), 6'(i), 6'(i));
        check("t2_count_full", count, 32);
        check("t2_ready_full", alloc_ready, 0);
        check("t2_index_wrap", alloc_index, 0);
        set_cmp(5'd0, 1'b0); tick(); clr_cmp();
        check("t2_commit_id", commit_instruction_ID, 200);
        check("t2_ready_still0", alloc_ready, 0);
        tick();
        check("t2_count31", count, 31);
        check("t2_ready_back", alloc_ready, 1);
        check("t2_index0", alloc_index, 0);
        do_alloc(32'd250, 5'd1, 6'd1, 6'd1);
        check("t2_index1", alloc_index, 1);
        check("t2_count32", count, 32);

        // Mispredict with three rollbacks
        reset_dut();
        for (int i = 0; i < 5; i++) do_alloc(32'(100 + i), 5'(i + 1), 6'(20 + i), 6'(10 + i));
        set_cmp(5'd1, 1'b1); #1;
        check("t3_ready_on_mp", alloc_ready, 0);
        tick(); clr_cmp();
        check("t3_flush_valid", flush_valid, 1);
        check("t3_flush_id", flushed_instruction_ID, 101);
        check("t3_flushing", flushing, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            check("t3_rb_valid", rollback_valid, 1);
            check("t3_rb_arch", rollback_arch_rw, 5 - k);
            check("t3_rb_prev", rollback_prev_phys, 14 - k);
            check("t3_rb_free", rollback_free_phys, 24 - k);
        end
        tick();
        check("t3_rb_stop", rollback_valid, 0);
        check("t3_flushing_end", flushing, 1);
        tick();
        check("t3_flush_done", flush_done, 1);
        check("t3_flushing_off", flushing, 0);
        check("t3_ready_after", alloc_ready, 1);
        check("t3_tail", alloc_index, 2);
        check("t3_count", count, 2);
        tick();
        check("t3_flush_done_pulse", flush_done, 0);

        // Mispredict on the youngest entry
        do_alloc(32'd110, 5'd7, 6'd40, 6'd30);
        set_cmp(5'd2, 1'b1); tick(); clr_cmp();
        check("t4_flush_valid", flush_valid, 1);
        check("t4_flush_id", flushed_instruction_ID, 110);
        check("t4_no_rb", rollback_valid, 0);
        tick();
        check("t4_flush_done", flush_done, 1);
        check("t4_no_rb2", rollback_valid, 0);
        check("t4_count", count, 3);
        check("t4_flushing", flushing, 0);

        // Retarget to an older branch mid-walk; younger one ignored
        reset_dut();
        for (int i = 0; i < 10; i++) do_alloc(32'(300 + i), 5'(i + 1), 6'(20 + i), 6'(10 + i));
        set_cmp(5'd6, 1'b1); tick();
        check("t5_flush_valid1", flush_valid, 1);
        check("t5_flush_id1", flushed_instruction_ID, 306);
        set_cmp(5'd7, 1'b1); #1;
        check("t5_rb_idx9", rollback_arch_rw, 10);
        tick(); clr_cmp(); #1;
        check("t5_younger_ignored", flush_valid, 0);
        check("t5_rb_idx8", rollback_arch_rw, 9);
        set_cmp(5'd3, 1'b1); tick(); clr_cmp();
        check("t5_flush_valid2", flush_valid, 1);
        check("t5_flush_id2", flushed_instruction_ID, 303);
        check("t5_rb_idx8_again", rollback_arch_rw, 9);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_rb_arch", rollback_arch_rw, 8 - k);
            check("t5_no_done", flush_done, 0);
        end
        tick();
        check("t5_rb_stop", rollback_valid, 0);
        check("t5_no_done_end", flush_done, 0);
        tick();
        check("t5_flush_done", flush_done, 1);
        check("t5_tail", alloc_index, 4);
        check("t5_count", count, 4);
        tick();
        check("t5_single_done", flush_done, 0);

        // Reset during rollback
        reset_dut();
        for (int i = 0; i < 6; i++) do_alloc(32'(400 + i), 5'(i + 1), 6'(20 + i), 6'(10 + i));
        set_cmp(5'd0, 1'b1); tick(); clr_cmp();
        tick();
        check("t6_mid_walk", flushing, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_count", count, 0);
        check("t6_flushing", flushing, 0);
        check("t6_rb", rollback_valid, 0);
        check("t6_ready", alloc_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_index0", alloc_index, 0);
        do_alloc(32'd500, 5'd3, 6'd3, 6'd3);
        check("t6_no_done", flush_done, 0);
        check("t6_count1", count, 1);
        check("t6_index1", alloc_index, 1);
        tick();
        check("t6_no_done2", flush_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
